cnn_layer_seq: RTL and testbench

Top-level layer scheduler for the LeNet-5 accelerator. It runs the layer engines (conv1, pool1, conv2, pool2, ...) one at a time through per-layer start/done handshakes. For the active layer it drives the BRAM base-address configuration: input source, weight base and output region. Output regions ping-pong inside the TEMP BRAM so each layer reads the previous layer's result. A per-layer watchdog and a run cycle counter provide fault detection and performance data.

---
 rtl/cnn_layer_seq_if.sv | 56 +++++
 rtl/cnn_layer_seq.sv | 206 ++++++++++++++++++++
 tb/tb_cnn_layer_seq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_seq_if.sv
// ---------------------------------------------------------------------------
// cnn_layer_seq_if
//   Control/configuration bundle between the LeNet-5 layer scheduler and its
//   surroundings (host control, layer engines, BRAM address configuration).
//
//   Handshake semantics: `start` is a request sampled only while the scheduler
//   is idle; each `layer_start` bit is a one-cycle pulse to one engine, and
//   the matching `layer_done` bit is the engine's completion (level or pulse),
//   observed only while that engine is the one being waited on.
//
//   Modports:
//     master : host/engine side (drives start, abort, layer_done)
//     slave  : the scheduler (drives status, layer_start and configuration)
//
//   Signals:
//     start, abort       run request / synchronous abort
//     done, error, busy  run status levels
//     layer_start        one-hot per-engine start pulse
//     layer_done         per-engine completion
//     cur_layer          active (or last) layer index
//     in_sel, in_base    input source select and base address
//     w_base, out_base   weight base and TEMP output base
//     run_cycles         saturating run-length counter
//     state_dbg          scheduler FSM state, for observation only
// ---------------------------------------------------------------------------
interface cnn_layer_seq_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned ADDR_W     = 32
);
    logic                  start;
    logic                  abort;
    logic                  done;
    logic                  error;
    logic                  busy;
    logic [NUM_LAYERS-1:0] layer_start;
    logic [NUM_LAYERS-1:0] layer_done;
    logic [2:0]            cur_layer;
    logic                  in_sel;
    logic [ADDR_W-1:0]     in_base;
    logic [ADDR_W-1:0]     w_base;
    logic [ADDR_W-1:0]     out_base;
    logic [31:0]           run_cycles;
    logic [2:0]            state_dbg;

    modport master (
        output start, abort, layer_done,
        input  done, error, busy, layer_start, cur_layer, in_sel,
               in_base, w_base, out_base, run_cycles, state_dbg
    );

    modport slave (
        input  start, abort, layer_done,
        output done, error, busy, layer_start, cur_layer, in_sel,
               in_base, w_base, out_base, run_cycles, state_dbg
    );
endinterface

// File: rtl/cnn_layer_seq.sv
// ---------------------------------------------------------------------------
// cnn_layer_seq
//   Layer scheduler for the LeNet-5 accelerator. Runs the layer engines one
//   at a time (ISSUE a start pulse, WAIT for that engine's done, NEXT layer),
//   and drives the BRAM base-address configuration for the active layer.
//   Output regions ping-pong between REGION_A_BASE and REGION_B_BASE in the
//   TEMP BRAM so every layer reads its predecessor's result. A per-layer
//   watchdog flags a hung engine; run_cycles measures the whole run.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : cnn_layer_seq_if.slave (control, engine handshake, config, status)
// ---------------------------------------------------------------------------
module cnn_layer_seq #(
    parameter int unsigned                  NUM_LAYERS    = 4,
    parameter int unsigned                  ADDR_W        = 32,
    parameter logic [NUM_LAYERS*ADDR_W-1:0] W_BASE_TABLE  = {32'h0C00, 32'h0200, 32'h0100, 32'h0000},
    parameter logic [ADDR_W-1:0]            REGION_A_BASE = 32'h0000,
    parameter logic [ADDR_W-1:0]            REGION_B_BASE = 32'h1000,
    parameter int unsigned                  TIMEOUT_CYC   = 1000000
) (
    input logic            clk,
    input logic            rst,
    cnn_layer_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [2:0]            LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] ONE_HOT0   = NUM_LAYERS'(1);

    state_t                 state;
    state_t                 state_nx;

    logic                   done_q;
    logic                   error_q;
    logic [2:0]             cur_layer_q;
    logic                   in_sel_q;
    logic [ADDR_W-1:0]      in_base_q;
    logic [ADDR_W-1:0]      w_base_q;
    logic [ADDR_W-1:0]      out_base_q;
    logic [31:0]            run_cycles_q;
    logic [31:0]            wd_cnt;
    // Set once the current engine's done line has been seen low after its
    // ISSUE, so a level left high from an earlier run cannot complete a layer.
    logic                   armed;

    logic [NUM_LAYERS-1:0]  cur_mask;
    logic                   cur_done;
    logic                   accept;
    logic                   busy_w;
    logic                   abort_hit;

    function automatic logic [ADDR_W-1:0] w_of(input logic [2:0] idx);
        w_of = W_BASE_TABLE[int'(idx)*ADDR_W +: ADDR_W];
    endfunction

    assign cur_mask  = ONE_HOT0 << cur_layer_q;
    assign cur_done  = |(bus.layer_done & cur_mask);
    assign accept    = armed && cur_done;
    assign busy_w    = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);
    assign abort_hit = bus.abort && (state != S_IDLE);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic; abort overrides every transition
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                // A completion in the same cycle as expiry wins.
                if (accept) begin
                    state_nx = S_NEXT;
                end else if (wd_cnt == TIMEOUT_CYC - 1) begin
                    state_nx = S_ERR;
                end
            end
            S_NEXT: begin
                if (cur_layer_q == LAST_LAYER) begin
                    state_nx = S_FIN;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nx = S_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: configuration, status, watchdog and run counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cur_layer_q  <= 3'd0;
            in_sel_q     <= 1'b0;
            in_base_q    <= '0;
            w_base_q     <= W_BASE_TABLE[ADDR_W-1:0];
            out_base_q   <= REGION_A_BASE;
            run_cycles_q <= 32'd0;
            wd_cnt       <= 32'd0;
            armed        <= 1'b0;
        end else if (abort_hit) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (busy_w && (run_cycles_q != 32'hFFFF_FFFF)) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        run_cycles_q <= 32'd0;
                        cur_layer_q  <= 3'd0;
                        in_sel_q     <= 1'b0;
                        in_base_q    <= '0;
                        w_base_q     <= w_of(3'd0);
                        out_base_q   <= REGION_A_BASE;
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= 32'd0;
                    armed  <= !cur_done;
                end
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 32'd1;
                    if (!cur_done) begin
                        armed <= 1'b1;
                    end
                end
                S_NEXT: begin
                    // Load the next layer's configuration so it is already
                    // stable in that layer's ISSUE cycle.
                    if (cur_layer_q != LAST_LAYER) begin
                        cur_layer_q <= cur_layer_q + 3'd1;
                        in_sel_q    <= 1'b1;
                        in_base_q   <= out_base_q;
                        out_base_q  <= (out_base_q == REGION_A_BASE) ? REGION_B_BASE
                                                                     : REGION_A_BASE;
                        w_base_q    <= w_of(cur_layer_q + 3'd1);
                    end
                end
                default: ;
            endcase

            // Status levels rise on entry to FIN/ERR and hold until the next start.
            if (state_nx == S_FIN) begin
                done_q <= 1'b1;
            end
            if (state_nx == S_ERR) begin
                done_q  <= 1'b1;
                error_q <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.busy        = busy_w;
    assign bus.layer_start = ((state == S_ISSUE) && !bus.abort) ? cur_mask : '0;
    assign bus.cur_layer   = cur_layer_q;
    assign bus.in_sel      = in_sel_q;
    assign bus.in_base     = in_base_q;
    assign bus.w_base      = w_base_q;
    assign bus.out_base    = out_base_q;
    assign bus.run_cycles  = run_cycles_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_cnn_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_seq
//   Directed bench for cnn_layer_seq (NUM_LAYERS=4, TIMEOUT_CYC=50).
//   A responder process models the engines (done pulse resp_lat cycles after
//   each start), a monitor logs every layer_start cycle with the
//   configuration seen alongside it, and the main sequence compares the log
//   against a hand-written expected table.
// ---------------------------------------------------------------------------
module tb_cnn_layer_seq;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_FIN  = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    // Expected per-layer configuration for a full run.
    logic        exp_sel [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_ib  [4] = '{32'h0000, 32'h0000, 32'h1000, 32'h0000};
    logic [31:0] exp_wb  [4] = '{32'h0000, 32'h0100, 32'h0200, 32'h0C00};
    logic [31:0] exp_ob  [4] = '{32'h0000, 32'h1000, 32'h0000, 32'h1000};

    logic        clk;
    logic        rst;
    logic [3:0]  resp_done;
    logic [3:0]  man_done;
    logic [3:0]  resp_en;
    int          resp_lat;

    logic [103:0] obs_q[$];
    logic [103:0] exp_q[$];
    int           obs_rd;
    int           n_checks;
    int           n_fail;

    cnn_layer_seq_if #(.NUM_LAYERS(4), .ADDR_W(32)) bus ();

    assign bus.layer_done = resp_done | man_done;

    cnn_layer_seq #(
        .NUM_LAYERS (4),
        .ADDR_W     (32),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "global timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [103:0] exp_rec(input int i);
        exp_rec = {4'(1 << i), 3'(i), exp_sel[i], exp_ib[i], exp_wb[i], exp_ob[i]};
    endfunction

    // Compare the layer_start log of the last run against the first n table rows.
    task automatic check_run(input int n_layers);
        logic [103:0] e;
        check("ls_count", obs_q.size() - obs_rd, n_layers);
        for (int i = 0; i < n_layers; i++) exp_q.push_back(exp_rec(i));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                check("ls_cfg", obs_q[obs_rd], e);
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (bus.layer_start != 4'b0000) begin
                obs_q.push_back({bus.layer_start, bus.cur_layer, bus.in_sel,
                                 bus.in_base, bus.w_base, bus.out_base});
            end
        end
    end

    // ---------------- engine responder ----------------
    initial begin
        int idx;
        resp_done = 4'b0000;
        forever begin
            @(negedge clk);
            if (bus.layer_start != 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (bus.layer_start[i]) idx = i;
                if (resp_en[idx]) begin
                    repeat (resp_lat) @(negedge clk);
                    resp_done[idx] = 1'b1;
                    @(negedge clk);
                    resp_done[idx] = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_ls(input int idx, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.layer_start[idx] && n < budget);
        if (!bus.layer_start[idx]) check("wait_ls_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < budget);
        if (!bus.done) check("wait_done_timeout", 0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wcnt;
        int n;
        n_checks  = 0;
        n_fail    = 0;
        obs_rd    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        man_done  = 4'b0000;
        resp_en   = 4'b1111;
        resp_lat  = 20;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state",    bus.state_dbg,   ST_IDLE);
        check("rst_done",     bus.done,        0);
        check("rst_error",    bus.error,       0);
        check("rst_busy",     bus.busy,        0);
        check("rst_ls",       bus.layer_start, 0);
        check("rst_cur",      bus.cur_layer,   0);
        check("rst_in_sel",   bus.in_sel,      0);
        check("rst_in_base",  bus.in_base,     32'h0000);
        check("rst_w_base",   bus.w_base,      32'h0000);
        check("rst_out_base", bus.out_base,    32'h0000);
        check("rst_cycles",   bus.run_cycles,  0);

        // Nominal run, with a start pulse injected while busy.
        pulse_start();
        repeat (30) @(negedge clk);
        check("nom_busy_mid", bus.busy, 1);
        pulse_start();
        wait_done(300);
        check("nom_done",   bus.done,       1);
        check("nom_error",  bus.error,      0);
        check("nom_busy",   bus.busy,       0);
        check("nom_state",  bus.state_dbg,  ST_FIN);
        check("nom_cycles", bus.run_cycles, 88);
        check("nom_cur",    bus.cur_layer,  3);
        repeat (3) @(negedge clk);
        check("nom_idle",      bus.state_dbg,  ST_IDLE);
        check("nom_done_hold", bus.done,       1);
        check("nom_frozen",    bus.run_cycles, 88);
        check_run(4);

        // Layer 0 done as a held level, spurious done[3] during layer 1.
        resp_en = 4'b1110;
        pulse_start();
        check("sp_done_clr", bus.done, 0);
        wait_ls(0, 5);
        repeat (5) @(negedge clk);
        man_done[0] = 1'b1;
        wait_ls(1, 10);
        repeat (3) @(negedge clk);
        man_done[3] = 1'b1;
        @(negedge clk);
        man_done[3] = 1'b0;
        @(negedge clk);
        check("sp_state", bus.state_dbg, ST_WAIT);
        check("sp_cur",   bus.cur_layer, 1);
        wait_done(300);
        check("sp_done",   bus.done,       1);
        check("sp_error",  bus.error,      0);
        check("sp_cycles", bus.run_cycles, 73);
        check_run(4);

        // Next run with layer_done[0] still high: must wait for a fresh done.
        pulse_start();
        wait_ls(0, 5);
        repeat (10) @(negedge clk);
        check("stale_state", bus.state_dbg, ST_WAIT);
        check("stale_cur",   bus.cur_layer, 0);
        man_done[0] = 1'b0;
        repeat (3) @(negedge clk);
        man_done[0] = 1'b1;
        @(negedge clk);
        man_done[0] = 1'b0;
        wait_ls(1, 10);
        wait_done(300);
        check("stale_done",   bus.done,       1);
        check("stale_cycles", bus.run_cycles, 81);
        check_run(4);

        // Watchdog: layer 1 never answers.
        resp_en = 4'b1101;
        pulse_start();
        wait_ls(1, 60);
        wcnt = 0;
        n    = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.state_dbg == ST_WAIT) wcnt++;
        end while (!bus.error && n < 200);
        check("to_wait_cycles", wcnt,           50);
        check("to_elapsed",     n,              51);
        check("to_error",       bus.error,      1);
        check("to_done",        bus.done,       1);
        check("to_busy",        bus.busy,       0);
        check("to_cur",         bus.cur_layer,  1);
        check("to_state",       bus.state_dbg,  ST_ERR);
        check("to_cycles",      bus.run_cycles, 73);
        @(negedge clk);
        check("to_idle",       bus.state_dbg, ST_IDLE);
        check("to_error_hold", bus.error,     1);
        check_run(2);

        // Abort during WAIT of layer 2.
        resp_en = 4'b1111;
        pulse_start();
        check("ab_error_clr", bus.error, 0);
        wait_ls(2, 60);
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("ab_state",  bus.state_dbg,  ST_IDLE);
        check("ab_done",   bus.done,       0);
        check("ab_error",  bus.error,      0);
        check("ab_busy",   bus.busy,       0);
        check("ab_cycles", bus.run_cycles, 49);
        repeat (30) @(negedge clk);
        check("ab_still_idle", bus.state_dbg,  ST_IDLE);
        check("ab_frozen",     bus.run_cycles, 49);
        check_run(3);
        pulse_start();
        wait_done(300);
        check("ab_rerun_done",   bus.done,       1);
        check("ab_rerun_cycles", bus.run_cycles, 88);
        check_run(4);

        // Asynchronous reset while waiting on layer 2.
        pulse_start();
        wait_ls(2, 60);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mr_state",    bus.state_dbg,   ST_IDLE);
        check("mr_busy",     bus.busy,        0);
        check("mr_done",     bus.done,        0);
        check("mr_ls",       bus.layer_start, 0);
        check("mr_cur",      bus.cur_layer,   0);
        check("mr_in_sel",   bus.in_sel,      0);
        check("mr_in_base",  bus.in_base,     32'h0000);
        check("mr_w_base",   bus.w_base,      32'h0000);
        check("mr_out_base", bus.out_base,    32'h0000);
        check("mr_cycles",   bus.run_cycles,  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_run(3);
        pulse_start();
        wait_done(300);
        check("mr_rerun_done",   bus.done,       1);
        check("mr_rerun_cycles", bus.run_cycles, 88);
        check_run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
